adc_sample_sequencer: RTL and testbench

- Controller for the PMU ADC front end (AD7606-style simultaneous-sampling ADC).
- Drives the 7 ADC control pins (CONVST, RESET, RANGE, OS[2:0], STBY_n).
- Waits out BUSY, then issues NUM_CH word reads to the ADC SPI master via a req/ack handshake.
- Emits a tagged sample stream to the phasor datapath. Conversions start on `sample_tick` from the GPS-disciplined timebase.

---
 rtl/adc_sample_sequencer.sv | 216 +++++++++++++++++++++
 tb/tb_adc_sample_sequencer.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_sample_sequencer.sv
// Conversion sequencer for an AD7606-style ADC: drives the control pins, waits out BUSY,
// reads NUM_CH words through the SPI master handshake and emits a tagged sample stream.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// OFF       | disabled, control pins at reset values
// ARST      | ADC RESET pin held high for RESET_CYC clocks
// IDLE      | tracking cfg, waiting for sample_tick
// CNV       | CONVST held low for CONVST_LOW_CYC clocks
// WAIT_FALL | waiting for BUSY high then low, bounded by BUSY_TIMEOUT
// READ      | one SPI word read per channel
// DRAIN     | enable dropped with a read outstanding; wait for ack, discard
module adc_sample_sequencer #(
    parameter int NUM_CH         = 8,
    parameter int DATA_W         = 16,
    parameter int CONVST_LOW_CYC = 2,
    parameter int RESET_CYC      = 4,
    parameter int BUSY_TIMEOUT   = 1023
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic [2:0]        cfg_os,
    input  logic              cfg_range,
    input  logic              sample_tick,
    input  logic              adc_busy,
    output logic [6:0]        adc_ctrl,
    output logic              spi_req,
    input  logic              spi_ack,
    input  logic [DATA_W-1:0] spi_rdata,
    output logic              smp_valid,
    output logic [2:0]        smp_ch,
    output logic [DATA_W-1:0] smp_data,
    output logic              smp_last,
    output logic              overrun,
    output logic              timeout_err
);

    localparam int PH_MAX = (RESET_CYC > CONVST_LOW_CYC) ? RESET_CYC : CONVST_LOW_CYC;
    localparam int PH_W   = $clog2(PH_MAX + 1);
    localparam int TMO_W  = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [2:0] LAST_CH = 3'(NUM_CH - 1);
    localparam logic [6:0] CTRL_RST = 7'b100_0001;

    typedef enum logic [2:0] {
        S_OFF,
        S_ARST,
        S_IDLE,
        S_CNV,
        S_WAIT_FALL,
        S_READ,
        S_DRAIN
    } state_t;

    state_t             state_q, state_d;
    logic [PH_W-1:0]    ph_q, ph_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [2:0]         ch_q, ch_d;
    logic               busy_seen_q, busy_seen_d;

    logic               convst_d, rst_d, range_d;
    logic [2:0]         os_d;
    logic               spi_req_d, smp_valid_d, smp_last_d, overrun_d, timeout_err_d;
    logic [2:0]         smp_ch_d;
    logic [DATA_W-1:0]  smp_data_d;

    logic               acked;
    logic               busy_fall;

    assign acked     = spi_req && spi_ack;
    assign busy_fall = busy_seen_q && !adc_busy;

    always_ff @(posedge clk or negedge reset_n) begin : state_reg
        if (!reset_n) begin
            state_q     <= S_OFF;
            ph_q        <= '0;
            tmo_q       <= '0;
            ch_q        <= '0;
            busy_seen_q <= 1'b0;
            adc_ctrl    <= CTRL_RST;
            spi_req     <= 1'b0;
            smp_valid   <= 1'b0;
            smp_ch      <= '0;
            smp_data    <= '0;
            smp_last    <= 1'b0;
            overrun     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state_q     <= state_d;
            ph_q        <= ph_d;
            tmo_q       <= tmo_d;
            ch_q        <= ch_d;
            busy_seen_q <= busy_seen_d;
            adc_ctrl    <= {1'b1, os_d, range_d, rst_d, convst_d};
            spi_req     <= spi_req_d;
            smp_valid   <= smp_valid_d;
            smp_ch      <= smp_ch_d;
            smp_data    <= smp_data_d;
            smp_last    <= smp_last_d;
            overrun     <= overrun_d;
            timeout_err <= timeout_err_d;
        end
    end

    always_comb begin : next_state_comb
        state_d = state_q;
        case (state_q)
            S_OFF: begin
                if (enable) state_d = S_ARST;
            end
            S_ARST: begin
                if (!enable)          state_d = S_OFF;
                else if (ph_q == '0)  state_d = S_IDLE;
            end
            S_IDLE: begin
                if (!enable)          state_d = S_OFF;
                else if (sample_tick) state_d = S_CNV;
            end
            S_CNV: begin
                if (!enable)          state_d = S_OFF;
                else if (ph_q == '0)  state_d = S_WAIT_FALL;
            end
            S_WAIT_FALL: begin
                if (!enable)          state_d = S_OFF;
                else if (busy_fall)   state_d = S_READ;
                else if (tmo_q == '0) state_d = S_ARST;
            end
            S_READ: begin
                // An ack arriving with enable low is discarded like any drained word.
                if (!enable)                       state_d = (spi_req && !spi_ack) ? S_DRAIN : S_OFF;
                else if (acked && ch_q == LAST_CH) state_d = S_IDLE;
            end
            S_DRAIN: begin
                if (spi_ack) state_d = S_OFF;
            end
            default: state_d = S_OFF;
        endcase
    end

    always_comb begin : output_comb
        ph_d          = ph_q;
        tmo_d         = (tmo_q != '0) ? tmo_q - 1'b1 : tmo_q;
        ch_d          = ch_q;
        busy_seen_d   = busy_seen_q;
        convst_d      = 1'b1;
        rst_d         = 1'b0;
        os_d          = adc_ctrl[5:3];
        range_d       = adc_ctrl[2];
        spi_req_d     = 1'b0;
        smp_valid_d   = 1'b0;
        smp_ch_d      = '0;
        smp_data_d    = '0;
        smp_last_d    = 1'b0;
        overrun_d     = sample_tick &&
                        (state_q inside {S_CNV, S_WAIT_FALL, S_READ, S_DRAIN});
        timeout_err_d = 1'b0;

        // Config tracks the inputs only while idle; the tick cycle's value is the one frozen.
        if (state_q == S_IDLE) begin
            os_d    = cfg_os;
            range_d = cfg_range;
        end

        case (state_d)
            S_OFF: begin
                os_d    = '0;
                range_d = 1'b0;
            end
            S_ARST: begin
                rst_d         = 1'b1;
                ph_d          = (state_q == S_ARST) ? ph_q - 1'b1 : PH_W'(RESET_CYC - 1);
                timeout_err_d = (state_q == S_WAIT_FALL);
            end
            S_IDLE: begin
                if (state_q == S_READ) begin
                    smp_valid_d = 1'b1;
                    smp_ch_d    = ch_q;
                    smp_data_d  = spi_rdata;
                    smp_last_d  = 1'b1;
                end
            end
            S_CNV: begin
                convst_d = 1'b0;
                if (state_q == S_CNV) begin
                    ph_d        = ph_q - 1'b1;
                    busy_seen_d = busy_seen_q | adc_busy;
                end else begin
                    ph_d        = PH_W'(CONVST_LOW_CYC - 1);
                    tmo_d       = TMO_W'(BUSY_TIMEOUT - 1);
                    busy_seen_d = 1'b0;
                end
            end
            S_WAIT_FALL: begin
                busy_seen_d = busy_seen_q | adc_busy;
            end
            S_READ: begin
                if (state_q != S_READ) begin
                    ch_d      = '0;
                    spi_req_d = 1'b1;
                end else if (acked) begin
                    smp_valid_d = 1'b1;
                    smp_ch_d    = ch_q;
                    smp_data_d  = spi_rdata;
                    ch_d        = ch_q + 3'd1;
                end else begin
                    spi_req_d = 1'b1;
                end
            end
            S_DRAIN: begin
                spi_req_d = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_adc_sample_sequencer.sv
// Directed bench for adc_sample_sequencer: an expected-sample queue plus handshake rules
// checked every cycle, and literal timing expectations for the directed scenarios.
module tb_adc_sample_sequencer;

    localparam int NCH = 8;
    localparam logic [6:0] CTRL_RST = 7'h41;

    logic        clk;
    logic        reset_n;
    logic        enable;
    logic [2:0]  cfg_os;
    logic        cfg_range;
    logic        sample_tick;
    logic        adc_busy;
    logic [6:0]  adc_ctrl;
    logic        spi_req;
    logic        spi_ack;
    logic [15:0] spi_rdata;
    logic        smp_valid;
    logic [2:0]  smp_ch;
    logic [15:0] smp_data;
    logic        smp_last;
    logic        overrun;
    logic        timeout_err;

    adc_sample_sequencer dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .cfg_os      (cfg_os),
        .cfg_range   (cfg_range),
        .sample_tick (sample_tick),
        .adc_busy    (adc_busy),
        .adc_ctrl    (adc_ctrl),
        .spi_req     (spi_req),
        .spi_ack     (spi_ack),
        .spi_rdata   (spi_rdata),
        .smp_valid   (smp_valid),
        .smp_ch      (smp_ch),
        .smp_data    (smp_data),
        .smp_last    (smp_last),
        .overrun     (overrun),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int n_smp = 0;
    int n_req = 0;
    int n_ovr = 0;
    int n_tmo = 0;
    int n_cnv = 0;

    logic [19:0] exp_q[$];
    bit          proto_en = 1'b1;

    bit          resp_en  = 1'b1;
    int          ack_dly  = 5;
    int          hold_ch  = -1;
    int          age      = 0;
    int          rd_idx   = 0;
    logic [15:0] rd_base  = 16'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: inputs change 1 time unit after the edge; the SPI responder lives here too.
    task automatic step();
        @(posedge clk);
        #1;
        sample_tick = 1'b0;
        spi_ack     = 1'b0;
        spi_rdata   = 16'hdead;
        if (resp_en && spi_req && rd_idx != hold_ch) begin
            age++;
            if (age >= ack_dly) begin
                spi_ack   = 1'b1;
                spi_rdata = rd_base + 16'(rd_idx);
                rd_idx++;
                age = 0;
            end
        end
    endtask

    // Sample stream and handshake rules, checked on the falling edge.
    initial begin : compare
        logic        prev_req, prev_ack, prev_en, prev_convst;
        logic [19:0] e;
        prev_req = 1'b0; prev_ack = 1'b0; prev_en = 1'b0; prev_convst = 1'b1;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                prev_req = 1'b0; prev_ack = 1'b0; prev_en = 1'b0; prev_convst = 1'b1;
            end else begin
                if (smp_valid) begin
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL smp_unexpected: got ch=%0d data=%0h, want no sample", smp_ch, smp_data);
                    end else begin
                        e = exp_q.pop_front();
                        chk("smp_word", {12'h0, smp_last, smp_ch, smp_data}, {12'h0, e});
                    end
                    n_smp++;
                end
                if (proto_en && prev_req && !prev_ack) chk("req_hold", spi_req, 1);
                if (proto_en && prev_req && prev_ack) begin
                    chk("req_gap", spi_req, 0);
                    chk("smp_lat", smp_valid, prev_en);
                end
                if (spi_req && !prev_req) n_req++;
                if (overrun) n_ovr++;
                if (timeout_err) n_tmo++;
                if (prev_convst && !adc_ctrl[0]) n_cnv++;
                prev_req = spi_req; prev_ack = spi_ack; prev_en = enable; prev_convst = adc_ctrl[0];
            end
        end
    end

    initial begin : watchdog
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic arst_len(output int cnt);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (adc_ctrl[1]) cnt++;
            else if (cnt > 0) break;
        end
    endtask

    task automatic start_conv(input logic [15:0] base, input int n_push, input bit dbl);
        logic [19:0] e;
        rd_base = base; rd_idx = 0; age = 0;
        for (int c = 0; c < n_push; c++) begin
            e = {(c == NCH - 1), 3'(c), base + 16'(c)};
            exp_q.push_back(e);
        end
        sample_tick = 1'b1;
        step();
        chk("convst_lat", adc_ctrl[0], 0);
        adc_busy = 1'b1;
        if (dbl) sample_tick = 1'b1;
        step();
        chk("convst_hold", adc_ctrl[0], 0);
        if (dbl) chk("ovr_dbl", overrun, 1);
        step();
        chk("convst_rise", adc_ctrl[0], 1);
        repeat (18) step();
        adc_busy = 1'b0;
        step();
        chk("req_lat", spi_req, 1);
    endtask

    task automatic run_frame(input logic [15:0] base, input bit dbl, input bit rtick, input bit cfgchg);
        int s0, r0, o0, c0;
        bit os_ok, chg;
        s0 = n_smp; r0 = n_req; o0 = n_ovr; c0 = n_cnv;
        os_ok = 1'b1; chg = 1'b0;
        start_conv(base, NCH, dbl);
        for (int i = 0; i < 400 && n_smp < s0 + NCH; i++) begin
            if (rtick && i == 10) sample_tick = 1'b1;
            step();
            if (rtick && i == 10) chk("ovr_read", overrun, 1);
            if (cfgchg) begin
                if (n_smp < s0 + NCH && adc_ctrl[5:2] != 4'b1011) os_ok = 1'b0;
                if (!chg && n_smp >= s0 + 1) begin
                    cfg_os = 3'b010; cfg_range = 1'b0; chg = 1'b1;
                end
            end
        end
        chk("frame_smp", n_smp - s0, NCH);
        chk("frame_req", n_req - r0, NCH);
        chk("frame_cnv", n_cnv - c0, 1);
        chk("frame_ovr", n_ovr - o0, int'(dbl) + int'(rtick));
        if (cfgchg) begin
            chk("cfg_frozen", os_ok, 1);
            for (int i = 0; i < 4 && adc_ctrl[5:2] != 4'b0100; i++) step();
            chk("cfg_applied", adc_ctrl, 7'h51);
        end
    endtask

    initial begin : main
        int cnt, s0, o0, tcyc;
        reset_n = 1'b0; enable = 1'b0; cfg_os = 3'b000; cfg_range = 1'b0;
        sample_tick = 1'b0; adc_busy = 1'b0; spi_ack = 1'b0; spi_rdata = 16'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ctrl", adc_ctrl, CTRL_RST);
        chk("rst_req", spi_req, 0);
        chk("rst_outs", {smp_valid, smp_last, overrun, timeout_err}, 0);
        reset_n = 1'b1;
        step(); step();
        chk("off_hold", adc_ctrl, CTRL_RST);

        // Basic frame
        enable = 1'b1;
        arst_len(cnt);
        chk("arst_len", cnt, 4);
        spi_ack = 1'b1; spi_rdata = 16'h5555;
        step(); step();
        run_frame(16'h1000, 1'b0, 1'b0, 1'b0);

        // Overrun: double tick and tick during READ
        run_frame(16'h2000, 1'b1, 1'b1, 1'b0);

        // BUSY timeout
        s0 = n_smp; o0 = n_ovr;
        sample_tick = 1'b1; adc_busy = 1'b1;
        step();
        chk("tmo_convst", adc_ctrl[0], 0);
        tcyc = 0;
        for (int j = 1; j <= 1100; j++) begin
            step();
            if (timeout_err) begin tcyc = j; break; end
        end
        chk("tmo_cycles", tcyc, 1023);
        chk("tmo_rst", adc_ctrl[1], 1);
        cnt = 1;
        sample_tick = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (i == 0) chk("tmo_pulse", timeout_err, 0);
            if (adc_ctrl[1]) cnt++;
            else break;
        end
        chk("tmo_arst_len", cnt, 4);
        chk("arst_no_ovr", n_ovr - o0, 0);
        chk("tmo_nosmp", n_smp - s0, 0);
        chk("tmo_count", n_tmo, 1);
        adc_busy = 1'b0;
        step();
        run_frame(16'h2200, 1'b0, 1'b0, 1'b0);

        // Config freeze
        cfg_os = 3'b101; cfg_range = 1'b1;
        step(); step();
        chk("cfg_idle", adc_ctrl, 7'h6D);
        run_frame(16'h4000, 1'b0, 1'b0, 1'b1);

        // Abort with ch 3 outstanding
        hold_ch = 3;
        s0 = n_smp;
        start_conv(16'h3000, 3, 1'b0);
        for (int i = 0; i < 200 && !(rd_idx == 3 && spi_req && !spi_ack); i++) step();
        chk("abort_pending", {rd_idx == 3, spi_req}, 2'b11);
        enable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("abort_req_hold", spi_req, 1);
        end
        spi_ack = 1'b1; spi_rdata = 16'hbeef;
        step();
        chk("abort_req_drop", spi_req, 0);
        chk("abort_ctrl", adc_ctrl, CTRL_RST);
        chk("abort_nosmp", smp_valid, 0);
        o0 = n_ovr;
        sample_tick = 1'b1;
        step(); step();
        chk("off_no_ovr", n_ovr - o0, 0);
        chk("off_ctrl", adc_ctrl, CTRL_RST);
        chk("abort_smp", n_smp - s0, 3);
        chk("exp_empty", exp_q.size(), 0);
        hold_ch = -1;

        // Async reset mid-READ
        enable = 1'b1;
        arst_len(cnt);
        chk("arst_len2", cnt, 4);
        s0 = n_smp;
        start_conv(16'h5000, NCH, 1'b0);
        for (int i = 0; i < 200 && n_smp < s0 + 2; i++) step();
        step();
        chk("pre_rst_req", spi_req, 1);
        #2;
        proto_en = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("arst_ctrl", adc_ctrl, CTRL_RST);
        chk("arst_req", spi_req, 0);
        chk("arst_outs", {smp_valid, smp_last, overrun, timeout_err, smp_ch}, 0);
        chk("arst_data", smp_data, 0);
        exp_q.delete();
        enable = 1'b0;
        step();
        reset_n = 1'b1;
        step(); step();
        chk("post_rst_ctrl", adc_ctrl, CTRL_RST);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
